fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2: instruction buffer entries; legal values are 2 and 4.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn_i, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port imem_req_o, output, 1: instruction memory request.
REQ-006 SHALL have port imem_addr_o, output, ADDR_SIZE: request address.
REQ-007 SHALL have port imem_gnt_i, input, 1: request accepted in this cycle.
REQ-008 SHALL have port imem_rvalid_i, input, 1: read data valid, exactly one cycle per granted request, in order.
REQ-009 SHALL have port imem_rdata_i, input, ISA_SIZE: fetched instruction.
REQ-010 SHALL have port redirect_i, input, 1: taken branch or jump.
REQ-011 SHALL have port redirect_pc_i, input, ADDR_SIZE: redirect target.
REQ-012 SHALL have port inst_ready_i, input, 1: decode stage accepts the instruction.
REQ-013 SHALL have port inst_valid_o, output, 1: inst_o and pc_o are valid.
REQ-014 SHALL have port inst_o, output, ISA_SIZE: instruction to decode.
REQ-015 SHALL have port pc_o, output, ADDR_SIZE: address of inst_o.

Function
REQ-016 SHALL keep at most one granted request outstanding.
REQ-017 SHALL implement FSM states FETCH (no request outstanding), WAIT (request outstanding) and DROP (outstanding response is stale).
REQ-018 SHALL assert imem_req_o in FETCH or WAIT when buffer occupancy plus outstanding count is below BUF_DEPTH.
- In WAIT, "outstanding" counts as 0 in a cycle with imem_rvalid_i=1; this permits back-to-back fetch.
REQ-019 SHALL hold imem_addr_o and imem_req_o stable until imem_gnt_i, except in a redirect cycle.
REQ-020 SHALL increment the fetch PC by 4 on each grant, wrapping modulo 2^ADDR_SIZE.
REQ-021 SHALL transition on grant without redirect to WAIT, and on rvalid with no new grant to FETCH.
REQ-022 SHALL push {fetch address, imem_rdata_i} into the buffer on imem_rvalid_i in WAIT.
REQ-023 SHALL discard imem_rvalid_i in DROP and then go to FETCH (or to WAIT if granted in that cycle).
REQ-024 SHALL present the buffer head as inst_valid_o/inst_o/pc_o and pop on inst_valid_o & inst_ready_i; 0-cycle bypass is not provided.
REQ-025 SHALL drive inst_o=NOP_INST (32'h0000_0013) and pc_o=last popped pc+4 (RESET_PC before the first pop) while the buffer is empty.
REQ-026 SHALL, on redirect_i:
- flush the buffer in the same cycle, so inst_valid_o=0 in the next cycle;
- load the fetch PC with redirect_pc_i and issue it in the next cycle;
- go to DROP if a request is outstanding or is granted in that cycle;
- discard a coincident imem_rvalid_i.
REQ-027 SHALL give redirect priority over a simultaneous push/pop; no pop is counted in the redirect cycle.
REQ-028 SHALL drop a new request when the buffer is full: no request, registered state held.

Reset
REQ-029 SHALL, while rstn_i=0: imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=NOP_INST, pc_o=RESET_PC, buffer empty, FSM=FETCH.
REQ-030 SHALL assert imem_req_o with imem_addr_o=RESET_PC in the first clock after rstn_i rises.
REQ-031 SHALL track no response across reset; instruction memory shares rstn_i, and reset mid-operation abandons the outstanding request.

Configuration
REQ-032 SHALL, with FETCH_MISALIGN_CHK_EN defined:
- add output misalign_o, 1 bit;
- a redirect with redirect_pc_i[1:0]!=0 sets misalign_o in the next cycle and halts requests;
- misalign_o clears on the next aligned redirect or on reset.
REQ-033 SHALL, without FETCH_MISALIGN_CHK_EN, omit misalign_o and force redirect_pc_i[1:0] to 2'b00.

Structure
REQ-034 SHALL add to lagarto0_pkg: NOP_INST, enum fetch_state_t {FETCH, WAIT, DROP}, struct fetch_entry_t {pc, inst}.
REQ-035 SHALL instantiate sub-module fetch_fifo with synchronous flush, count output, and BUF_DEPTH entries of fetch_entry_t.

Verification
REQ-036 SHALL cover reset release, RESET_PC=0x100, gnt=1, rvalid next cycle, ready=1 -> addresses 0x100, 0x104, 0x108 on consecutive cycles; pc_o/inst_o match with one instruction per cycle.
REQ-037 SHALL cover inst_ready_i=0 with BUF_DEPTH=2 -> exactly 2 entries buffered, imem_req_o=0, and no instruction lost after ready rises.
REQ-038 SHALL cover redirect to 0x200 while a request is outstanding -> the stale rvalid is dropped, the next imem_addr_o is 0x200, and the first valid pc_o is 0x200.
REQ-039 SHALL cover redirect with coincident rvalid and pop -> the buffer is empty next cycle and inst_o=0x00000013.
REQ-040 SHALL cover gnt held low for 5 cycles -> imem_addr_o is stable for all 5 cycles.
REQ-041 SHALL cover, with FETCH_MISALIGN_CHK_EN defined, redirect to 0x202 -> misalign_o=1 and imem_req_o=0; a later redirect to 0x300 clears misalign_o and fetch resumes at 0x300.

Source files
------------

// File: rtl/lagarto0_pkg.sv
// Shared fetch-stage types and constants for the lagarto0 front end.
package lagarto0_pkg;

  localparam int unsigned ADDR_SIZE = 32;
  localparam int unsigned ISA_SIZE  = 32;

  localparam logic [ISA_SIZE-1:0] NOP_INST = ISA_SIZE'(32'h0000_0013);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] pc;
    logic [ISA_SIZE-1:0]  inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer of fetch entries with synchronous flush and occupancy count.
module fetch_fifo
  import lagarto0_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             entry_i,
  input  logic                     pop_i,
  output fetch_entry_t             head_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != (PTR_W+1)'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is only looked at when the buffer is non-empty.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wptr_q] <= entry_i;
  end

  assign head_o  = mem[rptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding memory request, small buffer to decode, redirect flush.
// Optional misaligned-redirect detection is enabled with `define FETCH_MISALIGN_CHK_EN.
module fetch_stage
  import lagarto0_pkg::*;
#(
  parameter logic [ADDR_SIZE-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned          BUF_DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  output logic                 imem_req_o,
  output logic [ADDR_SIZE-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [ISA_SIZE-1:0]  imem_rdata_i,
  input  logic                 redirect_i,
  input  logic [ADDR_SIZE-1:0] redirect_pc_i,
  input  logic                 inst_ready_i,
  output logic                 inst_valid_o,
  output logic [ISA_SIZE-1:0]  inst_o,
  output logic [ADDR_SIZE-1:0] pc_o
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic                 misalign_o
`endif
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_t         state_q, state_d;
  logic [ADDR_SIZE-1:0] pc_q, req_pc_q, empty_pc_q, redirect_pc;
  logic [CNT_W-1:0]     count;
  logic [CNT_W:0]       occ_next;
  logic                 empty, push, pop, grant, halt, still_out;
  fetch_entry_t         head, entry;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q;

  assign redirect_pc = redirect_pc_i;
  assign halt        = misalign_q;
  assign misalign_o  = misalign_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)         misalign_q <= 1'b0;
    else if (redirect_i) misalign_q <= (redirect_pc_i[1:0] != 2'b00);
  end
`else
  assign redirect_pc = redirect_pc_i & ~ADDR_SIZE'(3);
  assign halt        = 1'b0;
`endif

  assign entry = '{pc: req_pc_q, inst: imem_rdata_i};

  // Request gating looks at occupancy after this cycle's push/pop so streaming is back-to-back.
  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    occ_next   = '0;
    imem_req_o = 1'b0;
    grant      = 1'b0;
    still_out  = 1'b0;
    state_d    = FETCH;

    push = (state_q == WAIT) && imem_rvalid_i && !redirect_i;
    pop  = !empty && inst_ready_i && !redirect_i;
    if (!redirect_i)
      occ_next = (CNT_W+1)'(count) + (CNT_W+1)'(push) - (CNT_W+1)'(pop);

    imem_req_o = rstn_i && !halt && (occ_next < (CNT_W+1)'(BUF_DEPTH)) &&
                 ((state_q == FETCH) || ((state_q == WAIT) && imem_rvalid_i));
    grant      = imem_req_o && imem_gnt_i;
    still_out  = (state_q != FETCH) && !imem_rvalid_i;

    if (grant)
      state_d = redirect_i ? DROP : WAIT;
    else if (still_out)
      state_d = (redirect_i || (state_q == DROP)) ? DROP : WAIT;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      empty_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      if (redirect_i)  pc_q <= redirect_pc;
      else if (grant)  pc_q <= pc_q + ADDR_SIZE'(4);
      if (grant)       req_pc_q <= pc_q;
      if (pop)         empty_pc_q <= head.pc + ADDR_SIZE'(4);
    end
  end

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (redirect_i),
    .push_i  (push),
    .entry_i (entry),
    .pop_i   (pop),
    .head_o  (head),
    .empty_o (empty),
    .count_o (count)
  );

  assign imem_addr_o  = pc_q;
  assign inst_valid_o = !empty;
  assign inst_o       = empty ? NOP_INST : head.inst;
  assign pc_o         = empty ? empty_pc_q : head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory responder plus queue-based model of the fetch stream.
module tb_fetch_stage;
  import lagarto0_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid, redirect, inst_ready, inst_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, pc;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .inst_ready_i  (inst_ready),
    .inst_valid_o  (inst_valid),
    .inst_o        (inst),
    .pc_o          (pc)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .misalign_o    (misalign)
`endif
  );

  int errors = 0;
  int checks = 0;

  typedef struct {logic [31:0] addr; bit stale;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;

  req_t        oq[$];
  ent_t        bq[$];
  int          wait_cnt;
  logic [31:0] m_pc, m_last;
  bit          m_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic model_reset();
    oq.delete();
    bq.delete();
    wait_cnt = 0;
    m_pc     = RST_PC;
    m_last   = RST_PC;
    m_mis    = 1'b0;
  endtask

  // One clock: drive inputs, compare all outputs against the model, then advance the model.
  task automatic step(input bit g, input bit r, input bit rd, input logic [31:0] rpc, input int lat);
    bit          rv, push, pop, req_e, grant;
    int          occ;
    logic [31:0] rv_addr;
    @(posedge clk);
    #1;
    rv      = (oq.size() > 0) && (wait_cnt == 0);
    rv_addr = rv ? oq[0].addr : 32'h0;
    imem_gnt    = g;
    inst_ready  = r;
    redirect    = rd;
    redirect_pc = rpc;
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_data(rv_addr) : $urandom();
    @(negedge clk);
    push  = rv && !oq[0].stale && !rd;
    pop   = (bq.size() > 0) && r && !rd;
    occ   = rd ? 0 : bq.size() + int'(push) - int'(pop);
    req_e = !m_mis && (occ < DEPTH) && ((oq.size() == 0) || (rv && !oq[0].stale));
    grant = req_e && g;

    check("imem_req_o", 32'(imem_req), 32'(req_e));
    check("imem_addr_o", imem_addr, m_pc);
    check("inst_valid_o", 32'(inst_valid), 32'(bq.size() > 0));
    check("inst_o", inst, (bq.size() > 0) ? bq[0].inst : 32'h0000_0013);
    check("pc_o", pc, (bq.size() > 0) ? bq[0].pc : m_last);
`ifdef FETCH_MISALIGN_CHK_EN
    check("misalign_o", 32'(misalign), 32'(m_mis));
`endif

    if (rv) void'(oq.pop_front());
    if (pop) begin
      m_last = bq[0].pc + 32'd4;
      void'(bq.pop_front());
    end
    if (push) bq.push_back('{pc: rv_addr, inst: mem_data(rv_addr)});
    if (rd) begin
      bq.delete();
      foreach (oq[k]) oq[k].stale = 1'b1;
    end
    if (grant) begin
      oq.push_back('{addr: m_pc, stale: rd});
      wait_cnt = lat;
    end else if (oq.size() > 0) begin
      wait_cnt--;
    end
`ifdef FETCH_MISALIGN_CHK_EN
    if (rd) begin
      m_pc  = rpc;
      m_mis = (rpc[1:0] != 2'b00);
    end else if (grant) begin
      m_pc = m_pc + 32'd4;
    end
`else
    if (rd)         m_pc = rpc & ~32'h3;
    else if (grant) m_pc = m_pc + 32'd4;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn        = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    inst_ready  = 1'b0;
    #2;
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_pc", pc, RST_PC);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_hold", 32'(imem_req), 32'h0);
    rstn = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          rd;
    logic [31:0] rpc;
    bit          seen;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    redirect = 0; redirect_pc = 0; inst_ready = 0;
    model_reset();
    do_reset();

    // Streaming from reset: one fetch and one instruction per cycle.
    step(1, 1, 0, 0, 0);
    check("first_req", 32'(imem_req), 32'h1);
    check("first_addr", imem_addr, 32'h0000_0100);
    step(1, 1, 0, 0, 0);
    check("addr_104", imem_addr, 32'h0000_0104);
    check("valid_lat", 32'(inst_valid), 32'h0);
    step(1, 1, 0, 0, 0);
    check("addr_108", imem_addr, 32'h0000_0108);
    check("pc_100", pc, 32'h0000_0100);
    check("inst_100", inst, 32'hFEFF_0100);
    step(1, 1, 0, 0, 0);
    check("pc_104", pc, 32'h0000_0104);
    step(1, 1, 0, 0, 0);
    check("pc_108", pc, 32'h0000_0108);

    // Decode stall: buffer fills to depth, requests stop, then exactly two drain.
    repeat (6) step(1, 0, 0, 0, 0);
    check("stall_req", 32'(imem_req), 32'h0);
    check("stall_valid", 32'(inst_valid), 32'h1);
    step(0, 1, 0, 0, 0);
    check("drain1_valid", 32'(inst_valid), 32'h1);
    step(0, 1, 0, 0, 0);
    check("drain2_valid", 32'(inst_valid), 32'h1);
    step(0, 1, 0, 0, 0);
    check("drain3_valid", 32'(inst_valid), 32'h0);

    // Grant withheld: address and request hold.
    step(0, 1, 1, 32'h0000_0500, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0);
      check("hold_addr", imem_addr, 32'h0000_0500);
      check("hold_req", 32'(imem_req), 32'h1);
    end

    // Redirect with a request outstanding: stale response dropped.
    step(1, 1, 0, 0, 2);
    step(1, 1, 1, 32'h0000_0200, 0);
    step(1, 0, 0, 0, 0);
    check("redir_addr", imem_addr, 32'h0000_0200);
    check("drop_req", 32'(imem_req), 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step(1, 0, 0, 0, 0);
      seen = inst_valid;
    end
    check("redir_seen", 32'(seen), 32'h1);
    check("redir_first_pc", pc, 32'h0000_0200);

    // Redirect coinciding with a response and a pop.
    repeat (4) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 32'h0000_0400, 0);
    check("flush_pre_valid", 32'(inst_valid), 32'h1);
    step(0, 1, 0, 0, 0);
    check("flush_valid", 32'(inst_valid), 32'h0);
    check("flush_inst", inst, 32'h0000_0013);

    // Randomized traffic with a mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      rd  = ($urandom_range(0, 99) < 4);
      rpc = $urandom();
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF8;
`ifdef FETCH_MISALIGN_CHK_EN
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
`endif
      step($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 60, rd, rpc,
           int'($urandom_range(0, 2)));
    end

`ifdef FETCH_MISALIGN_CHK_EN
    repeat (6) step(0, 1, 0, 0, 0);
    step(1, 1, 1, 32'h0000_0202, 0);
    step(1, 1, 0, 0, 0);
    check("mis_set", 32'(misalign), 32'h1);
    check("mis_req", 32'(imem_req), 32'h0);
    repeat (4) step(1, 1, 0, 0, 0);
    check("mis_halt", 32'(imem_req), 32'h0);
    step(1, 1, 1, 32'h0000_0300, 0);
    step(1, 1, 0, 0, 0);
    check("mis_clear", 32'(misalign), 32'h0);
    check("mis_resume_req", 32'(imem_req), 32'h1);
    check("mis_resume_addr", imem_addr, 32'h0000_0300);
    repeat (4) step(1, 1, 0, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
